// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for the shared multiply unit (MUL/MLA/UMULL/SMULL/UMLAL/SMLAL)
// Ports: clk/rst_n; start/flush issue control; i_* decoded fields; rf_rdata_b accumulate
// operand; mul_bus multiply result; rf_ra_a/rf_ra_b RF read addresses; mul_ld/mul_gate/
// mul_hilo/mul_signed multiply-unit controls; rf_we/rf_wa/rf_wd write-back; flag_we/
// flag_n/flag_z N/Z update; busy pipeline hold; done completion pulse.
module mul_seq_ctrl #(
    parameter int MUL_LATENCY = 1,
    parameter int REG_AW      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic              i_long,
    input  logic              i_signed,
    input  logic              i_acc,
    input  logic              i_s,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_rn,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rm,
    input  logic [31:0]       rf_rdata_b,
    input  logic [31:0]       mul_bus,
    output logic [REG_AW-1:0] rf_ra_a,
    output logic [REG_AW-1:0] rf_ra_b,
    output logic              mul_ld,
    output logic              mul_gate,
    output logic              mul_hilo,
    output logic              mul_signed,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [31:0]       rf_wd,
    output logic              flag_we,
    output logic              flag_n,
    output logic              flag_z,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, LO, HI, DN} state_t;
    state_t state;
    logic long_q, sgn_q, acc_q, s_q, carry, zlo, zhi, nq;
    logic [REG_AW-1:0] rd_q, rn_q, rs_q, rm_q;
    logic [3:0] cnt;
    logic [32:0] sum;
    logic in_lo, in_hi, in_dn;
    assign in_lo = state == LO;
    assign in_hi = state == HI;
    assign in_dn = state == DN;
    // the low-word carry only feeds the high-word add
    assign sum = {1'b0, mul_bus} + {1'b0, acc_q ? rf_rdata_b : 32'd0} + {32'd0, in_hi & carry};
    always_comb begin
        rf_ra_a    = state == LOAD ? rm_q : '0;
        rf_ra_b    = state == LOAD ? rs_q : in_lo ? rn_q : in_hi ? rd_q : '0;
        mul_ld     = state == LOAD;
        mul_signed = state == LOAD & long_q & sgn_q;
        mul_gate   = in_lo | in_hi;
        mul_hilo   = in_hi;
        rf_wa      = in_lo & long_q ? rn_q : (in_lo | in_hi) ? rd_q : '0;
        rf_wd      = (in_lo | in_hi) ? sum[31:0] : 32'd0;
        // register 15 is never written by this unit
        rf_we      = (in_lo | in_hi) & ~flush & (rf_wa != REG_AW'(15));
        flag_we    = in_dn & s_q & ~flush;
        flag_n     = in_dn & nq;
        flag_z     = in_dn & zlo & (~long_q | zhi);
        busy       = state != IDLE;
        done       = in_dn & ~flush;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            long_q <= 1'b0;
            sgn_q  <= 1'b0;
            acc_q  <= 1'b0;
            s_q    <= 1'b0;
            rd_q   <= '0;
            rn_q   <= '0;
            rs_q   <= '0;
            rm_q   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            zlo    <= 1'b0;
            zhi    <= 1'b0;
            nq     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    long_q <= i_long;
                    sgn_q  <= i_signed;
                    acc_q  <= i_acc;
                    s_q    <= i_s;
                    rd_q   <= i_rd;
                    rn_q   <= i_rn;
                    rs_q   <= i_rs;
                    rm_q   <= i_rm;
                    cnt    <= 4'(MUL_LATENCY - 1);
                end
                LOAD: if (cnt == 4'd0) state <= LO; else cnt <= cnt - 4'd1;
                LO: begin
                    carry <= long_q & sum[32];
                    zlo   <= sum[31:0] == 32'd0;
                    nq    <= sum[31];
                    state <= long_q ? HI : DN;
                end
                HI: begin
                    zhi   <= sum[31:0] == 32'd0;
                    nq    <= sum[31];
                    state <= DN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed self-checking bench for mul_seq_ctrl (latency 1 and 3 instances)
module tb_mul_seq_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic i_long = 1'b0, i_signed = 1'b0, i_acc = 1'b0, i_s = 1'b0;
    logic [3:0] i_rd = '0, i_rn = '0, i_rs = '0, i_rm = '0;
    logic [31:0] rf_rdata_b = '0, mul_bus = '0;
    logic [3:0] ra_a, ra_b, wa, ra_a3, ra_b3, wa3;
    logic ld, gate, hilo, sgn, we, fwe, fn, fz, busy, done;
    logic ld3, gate3, hilo3, sgn3, we3, fwe3, fn3, fz3, busy3, done3;
    logic [31:0] wd, wd3;
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.MUL_LATENCY(1), .REG_AW(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .i_long(i_long),
        .i_signed(i_signed), .i_acc(i_acc), .i_s(i_s), .i_rd(i_rd), .i_rn(i_rn),
        .i_rs(i_rs), .i_rm(i_rm), .rf_rdata_b(rf_rdata_b), .mul_bus(mul_bus),
        .rf_ra_a(ra_a), .rf_ra_b(ra_b), .mul_ld(ld), .mul_gate(gate), .mul_hilo(hilo),
        .mul_signed(sgn), .rf_we(we), .rf_wa(wa), .rf_wd(wd), .flag_we(fwe),
        .flag_n(fn), .flag_z(fz), .busy(busy), .done(done));

    mul_seq_ctrl #(.MUL_LATENCY(3), .REG_AW(4)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .i_long(i_long),
        .i_signed(i_signed), .i_acc(i_acc), .i_s(i_s), .i_rd(i_rd), .i_rn(i_rn),
        .i_rs(i_rs), .i_rm(i_rm), .rf_rdata_b(rf_rdata_b), .mul_bus(mul_bus),
        .rf_ra_a(ra_a3), .rf_ra_b(ra_b3), .mul_ld(ld3), .mul_gate(gate3), .mul_hilo(hilo3),
        .mul_signed(sgn3), .rf_we(we3), .rf_wa(wa3), .rf_wd(wd3), .flag_we(fwe3),
        .flag_n(fn3), .flag_z(fz3), .busy(busy3), .done(done3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic lng, input logic sg, input logic ac, input logic s,
                         input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rs,
                         input logic [3:0] rm);
        i_long = lng; i_signed = sg; i_acc = ac; i_s = s;
        i_rd = rd; i_rn = rn; i_rs = rs; i_rm = rm;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if ({busy, done, we, fwe, ld, gate, busy3} !== 7'b0) $display("FAIL reset_outs got %b want 0", {busy, done, we, fwe, ld, gate, busy3}); else pass++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy); else pass++;
    endtask

    task automatic test_mul();
        issue(0, 0, 0, 0, 4'd2, 4'd0, 4'd4, 4'd3);
        total++; if ({ld, gate, busy} !== 3'b101) $display("FAIL mul_load ld/gate/busy got %b want 101", {ld, gate, busy}); else pass++;
        total++; if ({ra_a, ra_b} !== 8'h34) $display("FAIL mul_load_addr got %h want 34", {ra_a, ra_b}); else pass++;
        tick();
        mul_bus = 32'd15; #1;
        total++; if ({we, gate, hilo, ld} !== 4'b1100) $display("FAIL mul_lo we/gate/hilo/ld got %b want 1100", {we, gate, hilo, ld}); else pass++;
        total++; if (wa !== 4'd2 || wd !== 32'd15) $display("FAIL mul_lo_write got wa=%0d wd=%0d want 2 15", wa, wd); else pass++;
        tick();
        total++; if ({done, we, gate, fwe} !== 4'b1000) $display("FAIL mul_done got %b want 1000", {done, we, gate, fwe}); else pass++;
        tick();
        total++; if ({busy, done} !== 2'b00) $display("FAIL mul_idle got %b want 00", {busy, done}); else pass++;
        mul_bus = 0;
    endtask

    task automatic test_umlal();
        issue(1, 0, 1, 1, 4'd0, 4'd1, 4'd2, 4'd3);
        total++; if (sgn !== 1'b0) $display("FAIL umlal_unsigned got %b want 0", sgn); else pass++;
        tick();
        mul_bus = 32'hFFFF_FFFF; rf_rdata_b = 32'd1; #1;
        total++; if ({we, wa, ra_b} !== 9'b1_0001_0001 || wd !== 32'd0) $display("FAIL umlal_lo got we/wa/ra_b=%b wd=%h want 100010001 0", {we, wa, ra_b}, wd); else pass++;
        tick();
        mul_bus = 32'd0; rf_rdata_b = 32'd0; #1;
        total++; if ({we, hilo, wa, ra_b} !== 10'b11_0000_0000 || wd !== 32'd1) $display("FAIL umlal_hi got %b wd=%h want 1100000000 1", {we, hilo, wa, ra_b}, wd); else pass++;
        tick();
        total++; if ({done, fwe, fn, fz} !== 4'b1100) $display("FAIL umlal_flags got %b want 1100", {done, fwe, fn, fz}); else pass++;
        tick();
    endtask

    task automatic test_smull();
        issue(1, 1, 0, 1, 4'd5, 4'd6, 4'd7, 4'd8);
        for (int c = 0; c < 3; c++) begin
            total++; if ({ld3, sgn3, gate3} !== 3'b110) $display("FAIL smull_load%0d ld/sgn/gate got %b want 110", c, {ld3, sgn3, gate3}); else pass++;
            tick();
        end
        mul_bus = 32'd0; #1;
        total++; if ({we3, gate3, hilo3, wa3} !== 7'b110_0110 || wd3 !== 32'd0) $display("FAIL smull_lo got %b wd=%h want 1100110 0", {we3, gate3, hilo3, wa3}, wd3); else pass++;
        tick();
        mul_bus = 32'hFFFF_FFFF; #1;
        total++; if ({we3, hilo3, wa3} !== 6'b11_0101 || wd3 !== 32'hFFFF_FFFF) $display("FAIL smull_hi got %b wd=%h want 110101 ffffffff", {we3, hilo3, wa3}, wd3); else pass++;
        tick();
        mul_bus = 32'd0; #1;
        total++; if ({done3, fwe3, fn3, fz3} !== 4'b1110) $display("FAIL smull_done_flags got %b want 1110", {done3, fwe3, fn3, fz3}); else pass++;
        tick();
        total++; if (busy3 !== 1'b0) $display("FAIL smull_idle busy got %b want 0", busy3); else pass++;
    endtask

    task automatic test_flush();
        issue(0, 0, 0, 1, 4'd2, 4'd0, 4'd1, 4'd1);
        tick();
        flush = 1'b1; #1;
        total++; if ({we, gate} !== 2'b01) $display("FAIL flush_lo we/gate got %b want 01", {we, gate}); else pass++;
        tick();
        flush = 1'b0; #1;
        total++; if ({busy, done, fwe} !== 3'b000) $display("FAIL flush_idle got %b want 000", {busy, done, fwe}); else pass++;
        tick();
        total++; if ({busy, done, fwe} !== 3'b000) $display("FAIL flush_nodone got %b want 000", {busy, done, fwe}); else pass++;
    endtask

    task automatic test_start_ignored();
        issue(1, 0, 0, 0, 4'd8, 4'd7, 4'd1, 4'd1);
        i_rd = 4'd9; i_rn = 4'd10; i_long = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; #1;
        total++; if ({we, wa} !== 5'b1_0111) $display("FAIL ign_load_lo we/wa got %b want 10111", {we, wa}); else pass++;
        start = 1'b1;
        tick();
        start = 1'b0; #1;
        total++; if ({we, hilo, wa} !== 6'b11_1000) $display("FAIL ign_hi got %b want 111000", {we, hilo, wa}); else pass++;
        tick();
        total++; if (done !== 1'b1) $display("FAIL ign_done got %b want 1", done); else pass++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL ign_idle busy got %b want 0", busy); else pass++;
    endtask

    task automatic test_reset_mid_hi();
        issue(1, 0, 0, 1, 4'd4, 4'd5, 4'd1, 4'd1);
        tick();
        tick();
        total++; if ({we, hilo} !== 2'b11) $display("FAIL rst_pre_hi got %b want 11", {we, hilo}); else pass++;
        rst_n = 1'b0; #1;
        total++; if ({we, gate, hilo, busy, wd} !== 36'd0) $display("FAIL rst_async got we/gate/hilo/busy=%b wd=%h want 0", {we, gate, hilo, busy}, wd); else pass++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if ({busy, done, fwe} !== 3'b000) $display("FAIL rst_after got %b want 000", {busy, done, fwe}); else pass++;
    endtask

    task automatic test_rd15();
        issue(0, 0, 1, 1, 4'd15, 4'd3, 4'd1, 4'd2);
        tick();
        mul_bus = 32'd0; rf_rdata_b = 32'd0; #1;
        total++; if ({we, gate, ra_b} !== 6'b01_0011) $display("FAIL rd15_lo we/gate/ra_b got %b want 010011", {we, gate, ra_b}); else pass++;
        tick();
        total++; if ({done, fwe, fn, fz} !== 4'b1101) $display("FAIL rd15_flags got %b want 1101", {done, fwe, fn, fz}); else pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_umlal();
        test_smull();
        test_flush();
        test_start_ignored();
        test_reset_mid_hi();
        test_rd15();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
